distribution_sched: RTL and testbench
=====================================

// Module: distribution_sched
// PURPOSE
//  Sequencer that drives the sparse-select inputs of the distribution mux network.
//  Accepts one sparsity window: a NUM_INPUT_DATA-bit nonzero mask per sub-macro.
//  Walks each mask lowest-set-bit first and emits one select beat per cycle until every mask is drained.
//  Stage-2 routing comes from a static route table, written while idle.
//  Sits between the sparsity-metadata fetch and the distribution block.
// PARAMETERS
//  NUM_SUB_MACROS  4  number of sub-macros / mux lanes
//  NUM_INPUT_DATA  4  candidates per lane; fixed at 4 (2-bit selects), other values unsupported
// PORTS
//  clk              in   1       clock
//  rst_n            in   1       asynchronous active-low reset
//  i_mask_valid     in   1       window mask valid
//  o_mask_ready     out  1       window mask accepted when valid&ready
//  i_mask           in   NSM*4   lane k mask at [4k+:4]; bit b set = candidate b nonzero
//  i_cfg_we         in   1       route table write strobe
//  i_cfg_route      in   NSM*2   stage-2 select for lane j at [2j+:2]
//  o_cfg_err        out  1       sticky: i_cfg_we seen while not IDLE
//  o_valid          out  1       select beat valid
//  i_ready          in   1       downstream accepts beat when o_valid&i_ready
//  o_sparse_select  out  NSM*4   [2k+:2]=stage-1 sel lane k; [2*NSM+2j+:2]=stage-2 sel lane j
//  o_lane_valid     out  NSM     lane k carries a real nonzero this beat
//  o_last           out  1       final beat of current window
//  o_busy           out  1       state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; o_valid, o_last, o_lane_valid, o_sparse_select, o_cfg_err = 0.
//   Route table = identity (lane j -> j). Any in-flight window is dropped, with no partial beat.
//  States:
//   IDLE  -> ISSUE on mask handshake.
//   ISSUE -> IDLE when the last beat is accepted and no new mask is taken that cycle.
//   ISSUE -> ISSUE (reload) when the last beat is accepted together with a new mask.
//  o_mask_ready = (state==IDLE) | (o_valid & i_ready & o_last); combinational, no bubble between windows.
//  Latency: mask accepted in cycle t -> first beat registered, o_valid=1 in cycle t+1.
//  Per beat, for each lane k, from the remaining mask rem[k]:
//   rem[k]!=0: stage-1 sel = index of lowest set bit; o_lane_valid[k]=1; that bit is cleared on acceptance.
//   rem[k]==0: stage-1 sel = 0; o_lane_valid[k]=0.
//  Stage-2 selects = route table, constant across a window.
//  o_last=1 on the beat after which every rem[] is zero.
//  Beats per window = max over lanes of popcount(mask), min 1.
//  All-zero window: exactly one beat, o_lane_valid=0, o_last=1, so downstream window counts stay aligned.
//  Stall: o_valid&!i_ready holds all outputs and rem[] unchanged; o_valid never drops until accepted.
//  Config: i_cfg_we in IDLE with no simultaneous mask handshake writes the table next edge.
//   i_cfg_we at any other time is ignored and sets o_cfg_err (cleared only by reset).
//   A window captures the table value present at its mask handshake.
//  All outputs except o_mask_ready are registered.
// TESTING
//  1 Reset, mask lanes {0:4'b1010,1:4'b0001,2:0,3:4'b1111}, i_ready=1 -> 4 beats.
//    lane0 sel 1,3 (lane_valid 1,1,0,0); lane1 sel 0 (1,0,0,0); lane2 lane_valid 0; lane3 sel 0,1,2,3; o_last on beat 4.
//  2 All-zero mask -> single beat, o_lane_valid=0000, o_last=1; state returns to IDLE next cycle.
//  3 Mask 4'b0110 all lanes, i_ready low 3 cycles on beat 1 -> beat 1 (sel=1) held stable,
//    then beat 2 (sel=2, last); exactly 2 accepted beats.
//  4 Two windows back-to-back, second valid during the last beat of the first ->
//    o_mask_ready=1 on that cycle, zero idle cycles between windows.
//  5 cfg_route={3,2,1,0} in IDLE, then a window -> stage-2 field = 8'b00_01_10_11 on every beat.
//    cfg_we during ISSUE -> table unchanged, o_cfg_err=1.
//  6 Assert rst_n=0 mid-window (beat 2 of 4) -> o_valid=0 immediately.
//    After release: IDLE, o_mask_ready=1, identity route restored.

Source files
------------

// File: rtl/distribution_sched.sv
// Sparse-select sequencer for the distribution mux network: drains one nonzero mask
// per lane lowest-set-bit first, one select beat per cycle, with a static stage-2 route table.
module distribution_sched #(
   parameter int NUM_SUB_MACROS = 4,
   parameter int NUM_INPUT_DATA = 4
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   i_mask_valid,
   output logic                                   o_mask_ready,
   input  logic [NUM_SUB_MACROS*NUM_INPUT_DATA-1:0] i_mask,
   input  logic                                   i_cfg_we,
   input  logic [NUM_SUB_MACROS*2-1:0]            i_cfg_route,
   output logic                                   o_cfg_err,
   output logic                                   o_valid,
   input  logic                                   i_ready,
   output logic [NUM_SUB_MACROS*4-1:0]            o_sparse_select,
   output logic [NUM_SUB_MACROS-1:0]              o_lane_valid,
   output logic                                   o_last,
   output logic                                   o_busy
);

   localparam int NSM = NUM_SUB_MACROS;
   localparam int ND  = NUM_INPUT_DATA;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   // Index of the lowest set bit of a 4-candidate mask (0 when empty).
   function automatic logic [1:0] lsb_idx(input logic [ND-1:0] m);
      logic [1:0] idx;
      casez (m)
         4'b???1: idx = 2'd0;
         4'b??10: idx = 2'd1;
         4'b?100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_valid;
   logic                 r_last;
   logic [NSM-1:0]       r_lane_valid;
   logic [NSM*4-1:0]     r_sel;
   logic [NSM*ND-1:0]    r_rem;
   logic [NSM*2-1:0]     r_route;
   logic                 r_cfg_err;

   logic                 w_mask_hs;
   logic                 w_accept;
   logic                 w_mask_ready;
   logic [NSM*ND-1:0]    w_src;
   logic [NSM*2-1:0]     w_sel1;
   logic [NSM-1:0]       w_lvalid;
   logic [NSM*ND-1:0]    w_rem_nxt;
   logic                 w_last;

   assign w_accept     = r_valid & i_ready;
   assign w_mask_ready = (r_state == ST_IDLE) | (w_accept & r_last);
   assign w_mask_hs    = i_mask_valid & w_mask_ready;

   // Next beat: from a freshly accepted mask, otherwise from what remains of the window.
   always_comb begin
      w_src     = r_rem;
      w_sel1    = {(NSM*2){1'b0}};
      w_lvalid  = {NSM{1'b0}};
      w_rem_nxt = {(NSM*ND){1'b0}};
      if (w_mask_hs) begin
         w_src = i_mask;
      end else begin
         w_src = r_rem;
      end
      for (int k = 0; k < NSM; k++) begin
         logic [ND-1:0] lane_v;
         lane_v                = w_src[ND*k +: ND];
         w_sel1[2*k +: 2]      = lsb_idx(lane_v);
         w_lvalid[k]           = |lane_v;
         w_rem_nxt[ND*k +: ND] = lane_v & (lane_v - 4'd1);
      end
      w_last = (w_rem_nxt == {(NSM*ND){1'b0}});
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a last-beat accept with a new mask reloads without leaving ISSUE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_mask_hs) w_state_nxt = ST_ISSUE;
            else           w_state_nxt = ST_IDLE;
         end
         ST_ISSUE: begin
            if (w_accept && r_last && !w_mask_hs) w_state_nxt = ST_IDLE;
            else                                  w_state_nxt = ST_ISSUE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Beat output registers and remaining-mask bookkeeping; stalls hold everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid      <= 1'b0;
         r_last       <= 1'b0;
         r_lane_valid <= {NSM{1'b0}};
         r_sel        <= {(NSM*4){1'b0}};
         r_rem        <= {(NSM*ND){1'b0}};
      end else if (w_mask_hs) begin
         r_valid      <= 1'b1;
         r_last       <= w_last;
         r_lane_valid <= w_lvalid;
         r_sel        <= {r_route, w_sel1};
         r_rem        <= w_rem_nxt;
      end else if (w_accept && r_last) begin
         r_valid      <= 1'b0;
         r_last       <= 1'b0;
         r_lane_valid <= {NSM{1'b0}};
         r_sel        <= {(NSM*4){1'b0}};
         r_rem        <= {(NSM*ND){1'b0}};
      end else if (w_accept) begin
         r_last             <= w_last;
         r_lane_valid       <= w_lvalid;
         r_sel[NSM*2-1:0]   <= w_sel1;
         r_rem              <= w_rem_nxt;
      end
   end

   // Route table writes only when idle and not racing a mask handshake; other writes flag an error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < NSM; j++) begin
            r_route[2*j +: 2] <= 2'(j);
         end
         r_cfg_err <= 1'b0;
      end else if (i_cfg_we) begin
         if ((r_state == ST_IDLE) && !w_mask_hs) begin
            r_route <= i_cfg_route;
         end else begin
            r_cfg_err <= 1'b1;
         end
      end
   end

   assign o_mask_ready    = w_mask_ready;
   assign o_valid         = r_valid;
   assign o_last          = r_last;
   assign o_lane_valid    = r_lane_valid;
   assign o_sparse_select = r_sel;
   assign o_cfg_err       = r_cfg_err;
   assign o_busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_distribution_sched.sv
// Directed self-checking bench for distribution_sched with hand-computed beat values.
module tb_distribution_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_mask_valid;
   logic        o_mask_ready;
   logic [15:0] i_mask;
   logic        i_cfg_we;
   logic [7:0]  i_cfg_route;
   logic        o_cfg_err;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_sparse_select;
   logic [3:0]  o_lane_valid;
   logic        o_last;
   logic        o_busy;

   int n_checks = 0;
   int n_errors = 0;
   int n_acc    = 0;

   distribution_sched #(.NUM_SUB_MACROS(4), .NUM_INPUT_DATA(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_mask_valid    (i_mask_valid),
      .o_mask_ready    (o_mask_ready),
      .i_mask          (i_mask),
      .i_cfg_we        (i_cfg_we),
      .i_cfg_route     (i_cfg_route),
      .o_cfg_err       (o_cfg_err),
      .o_valid         (o_valid),
      .i_ready         (i_ready),
      .o_sparse_select (o_sparse_select),
      .o_lane_valid    (o_lane_valid),
      .o_last          (o_last),
      .o_busy          (o_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (o_valid && i_ready) n_acc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input logic [15:0] sel, input logic [3:0] lv, input logic last);
      chk({tag, "_valid"}, 32'(o_valid), 32'd1);
      chk({tag, "_sel"},   32'(o_sparse_select), 32'(sel));
      chk({tag, "_lv"},    32'(o_lane_valid), 32'(lv));
      chk({tag, "_last"},  32'(o_last), 32'(last));
   endtask

   initial begin
      rst_n = 1'b0; i_mask_valid = 1'b0; i_mask = 16'h0000;
      i_cfg_we = 1'b0; i_cfg_route = 8'h00; i_ready = 1'b0;
      tick(); tick();
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_last", 32'(o_last), 32'd0);
      chk("rst_lv", 32'(o_lane_valid), 32'd0);
      chk("rst_sel", 32'(o_sparse_select), 32'd0);
      chk("rst_err", 32'(o_cfg_err), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_mready", 32'(o_mask_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      // 1: mixed lanes, 4 beats
      i_ready = 1'b1; i_mask = 16'hF01A; i_mask_valid = 1'b1;
      #1 chk("t1_mready_idle", 32'(o_mask_ready), 32'd1);
      tick(); i_mask_valid = 1'b0;
      chk_beat("t1_b1", 16'hE401, 4'b1011, 1'b0);
      chk("t1_busy", 32'(o_busy), 32'd1);
      chk("t1_mready_mid", 32'(o_mask_ready), 32'd0);
      tick(); chk_beat("t1_b2", 16'hE443, 4'b1001, 1'b0);
      tick(); chk_beat("t1_b3", 16'hE480, 4'b1000, 1'b0);
      tick(); chk_beat("t1_b4", 16'hE4C0, 4'b1000, 1'b1);
      chk("t1_mready_last", 32'(o_mask_ready), 32'd1);
      tick();
      chk("t1_done_valid", 32'(o_valid), 32'd0);
      chk("t1_done_busy", 32'(o_busy), 32'd0);

      // 2: all-zero window
      i_mask = 16'h0000; i_mask_valid = 1'b1;
      tick(); i_mask_valid = 1'b0;
      chk_beat("t2_b1", 16'hE400, 4'b0000, 1'b1);
      tick();
      chk("t2_done_valid", 32'(o_valid), 32'd0);
      chk("t2_done_busy", 32'(o_busy), 32'd0);

      // 3: stall on beat 1
      n_acc = 0;
      i_ready = 1'b0; i_mask = 16'h6666; i_mask_valid = 1'b1;
      tick(); i_mask_valid = 1'b0;
      chk_beat("t3_hold1", 16'hE455, 4'b1111, 1'b0);
      tick(); chk_beat("t3_hold2", 16'hE455, 4'b1111, 1'b0);
      tick(); chk_beat("t3_hold3", 16'hE455, 4'b1111, 1'b0);
      i_ready = 1'b1;
      tick(); chk_beat("t3_b2", 16'hE4AA, 4'b1111, 1'b1);
      tick();
      chk("t3_done_valid", 32'(o_valid), 32'd0);
      chk("t3_acc", 32'(n_acc), 32'd2);

      // 4: back-to-back windows
      i_mask = 16'h0003; i_mask_valid = 1'b1;
      tick(); i_mask_valid = 1'b0;
      chk_beat("t4_a1", 16'hE400, 4'b0001, 1'b0);
      tick(); chk_beat("t4_a2", 16'hE401, 4'b0001, 1'b1);
      i_mask = 16'h0004; i_mask_valid = 1'b1;
      #1 chk("t4_mready", 32'(o_mask_ready), 32'd1);
      tick(); i_mask_valid = 1'b0;
      chk_beat("t4_b1", 16'hE402, 4'b0001, 1'b1);
      chk("t4_busy", 32'(o_busy), 32'd1);
      tick();
      chk("t4_done_valid", 32'(o_valid), 32'd0);

      // 5: route table write and illegal write during ISSUE
      i_cfg_we = 1'b1; i_cfg_route = 8'h1B;
      tick(); i_cfg_we = 1'b0;
      i_mask = 16'h1111; i_mask_valid = 1'b1;
      tick(); i_mask_valid = 1'b0;
      chk_beat("t5_w1", 16'h1B00, 4'b1111, 1'b1);
      chk("t5_err0", 32'(o_cfg_err), 32'd0);
      tick();
      i_ready = 1'b0; i_mask = 16'h0003; i_mask_valid = 1'b1;
      tick(); i_mask_valid = 1'b0;
      chk_beat("t5_w2b1", 16'h1B00, 4'b0001, 1'b0);
      i_cfg_we = 1'b1; i_cfg_route = 8'hE4;
      tick(); i_cfg_we = 1'b0;
      chk("t5_err1", 32'(o_cfg_err), 32'd1);
      i_ready = 1'b1;
      tick(); chk_beat("t5_w2b2", 16'h1B01, 4'b0001, 1'b1);
      tick();
      i_mask = 16'h0001; i_mask_valid = 1'b1;
      tick(); i_mask_valid = 1'b0;
      chk_beat("t5_w3", 16'h1B00, 4'b0001, 1'b1);
      tick();

      // 6: reset mid-window
      i_mask = 16'hF000; i_mask_valid = 1'b1;
      tick(); i_mask_valid = 1'b0;
      chk_beat("t6_b1", 16'h1B00, 4'b1000, 1'b0);
      tick(); chk_beat("t6_b2", 16'h1B40, 4'b1000, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(o_valid), 32'd0);
      chk("t6_rst_busy", 32'(o_busy), 32'd0);
      chk("t6_rst_err", 32'(o_cfg_err), 32'd0);
      chk("t6_rst_sel", 32'(o_sparse_select), 32'd0);
      chk("t6_rst_mready", 32'(o_mask_ready), 32'd1);
      tick(); rst_n = 1'b1;
      tick();
      chk("t6_post_mready", 32'(o_mask_ready), 32'd1);
      i_mask = 16'h0001; i_mask_valid = 1'b1;
      tick(); i_mask_valid = 1'b0;
      chk_beat("t6_ident", 16'hE400, 4'b0001, 1'b1);
      tick();
      chk("t6_done_valid", 32'(o_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
